// File: rtl/mesh_sort_pe.sv
// One processing element of a SQRT_N x SQRT_N shear-sort mesh (snake order, data key, addr tiebreak).
// Optional: define MESH_SORT_PE_STATS_EN to add a saturating o_swaps exchange counter.
module mesh_sort_pe #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 3,
  parameter int SQRT_N     = 2,
  parameter int ROW        = 0,
  parameter int COL        = 0,
  parameter int PASSES     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_load,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_l,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_r,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_u,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_d,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
  output logic                             o_busy,
  output logic                             o_done
`ifdef MESH_SORT_PE_STATS_EN
  ,
  output logic [15:0]                      o_swaps
`endif
);

  localparam int W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int SW = (SQRT_N > 1) ? $clog2(SQRT_N) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(SQRT_N - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);
  localparam logic COL_ODD = ((COL % 2) == 1);
  localparam logic ROW_ODD = ((ROW % 2) == 1);
  localparam logic HAS_L   = (COL > 0);
  localparam logic HAS_R   = (COL < SQRT_N - 1);
  localparam logic HAS_U   = (ROW > 0);
  localparam logic HAS_D   = (ROW < SQRT_N - 1);

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_FINAL_ROW, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_step;
  logic [PW-1:0]   r_pass;
  logic [W-1:0]    r_pe;
  logic            w_last_step;
  logic            w_last_pass;
  logic            w_row_phase;
  logic            w_exch;
  logic            w_fwd;
  logic            w_has_partner;
  logic            w_keep_min;
  logic            w_partner_lt;
  logic [W-1:0]    w_partner;
  logic [W-1:0]    w_pe_nxt;

  // Data is the primary key, addr breaks ties.
  function automatic logic [W-1:0] sort_key(input logic [W-1:0] e);
    return {e[DATA_WIDTH-1:0], e[W-1:DATA_WIDTH]};
  endfunction

  assign w_last_step = (r_step == LAST_STEP);
  assign w_last_pass = (r_pass == LAST_PASS);
  assign o_PE        = r_pe;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE:      if (i_start) w_state_nxt = S_ROW;
      S_ROW: begin
        o_busy = 1'b1;
        if (w_last_step) w_state_nxt = S_COL;
      end
      S_COL: begin
        o_busy = 1'b1;
        if (w_last_step) w_state_nxt = w_last_pass ? S_FINAL_ROW : S_ROW;
      end
      S_FINAL_ROW: begin
        o_busy = 1'b1;
        if (w_last_step) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Forward partner (right/down) keeps the minimum in ascending order; odd rows run descending.
  always_comb begin
    w_row_phase = (r_state == S_ROW) || (r_state == S_FINAL_ROW);
    w_exch      = w_row_phase || (r_state == S_COL);
    if (w_row_phase) begin
      w_fwd         = ~(COL_ODD ^ r_step[0]);
      w_partner     = w_fwd ? i_PE_r : i_PE_l;
      w_has_partner = w_fwd ? HAS_R : HAS_L;
      w_keep_min    = w_fwd ^ ROW_ODD;
    end else begin
      w_fwd         = ~(ROW_ODD ^ r_step[0]);
      w_partner     = w_fwd ? i_PE_d : i_PE_u;
      w_has_partner = w_fwd ? HAS_D : HAS_U;
      w_keep_min    = w_fwd;
    end
    w_partner_lt = (sort_key(w_partner) < sort_key(r_pe));
    w_pe_nxt     = r_pe;
    if (w_exch && w_has_partner && (w_partner_lt == w_keep_min)) w_pe_nxt = w_partner;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_pass  <= '0;
      r_pe    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (i_start) begin
          r_pe   <= i_load;
          r_step <= '0;
          r_pass <= '0;
        end
      end else if (w_exch) begin
        r_pe   <= w_pe_nxt;
        r_step <= w_last_step ? '0 : r_step + 1'b1;
        if ((r_state == S_COL) && w_last_step && !w_last_pass) r_pass <= r_pass + 1'b1;
      end
    end
  end

`ifdef MESH_SORT_PE_STATS_EN
  logic [15:0] r_swaps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_swaps <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_swaps <= '0;
    end else if (w_exch && (w_pe_nxt != r_pe) && (r_swaps != 16'hFFFF)) begin
      r_swaps <= r_swaps + 16'd1;
    end
  end

  assign o_swaps = r_swaps;
`endif

endmodule

// File: tb/tb_mesh_sort_pe.sv
// Bench: a 3x3 mesh of mesh_sort_pe against an array-level shear-sort model, plus a 1x1 latency case.
module tb_mesh_sort_pe;

  localparam int DW = 3;
  localparam int AW = 3;
  localparam int W  = DW + AW;
  localparam int MN = 3;
  localparam int MP = 2;
  localparam int T  = (2 * MP + 1) * MN;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start1 = 1'b0;
  logic [W-1:0] r_load [MN][MN];
  logic [W-1:0] load1 = '0;
  logic [W-1:0] edge_l = '1, edge_r = '1, edge_u = '1, edge_d = '1;
  logic [W-1:0] w_out  [MN][MN];
  logic         w_busy [MN][MN];
  logic         w_done [MN][MN];
  logic [W-1:0] one_pe;
  logic         one_busy, one_done;
`ifdef MESH_SORT_PE_STATS_EN
  logic [15:0]  one_swaps;
`endif

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] mdl [MN][MN];
  logic [W-1:0] ld_saved [MN][MN];
  int           mk = 0;
  bit           chk_en = 1'b0;
  bit           rnd_edges = 1'b0;
  bit           rnd_start = 1'b0;

  always #5 clk = ~clk;

  for (genvar gr = 0; gr < MN; gr++) begin : g_row
    for (genvar gc = 0; gc < MN; gc++) begin : g_col
      logic [W-1:0] nl, nr, nu, nd;
`ifdef MESH_SORT_PE_STATS_EN
      logic [15:0]  swaps;
`endif
      if (gc > 0) begin : g_l
        assign nl = w_out[gr][gc-1];
      end else begin : g_le
        assign nl = edge_l;
      end
      if (gc < MN - 1) begin : g_r
        assign nr = w_out[gr][gc+1];
      end else begin : g_re
        assign nr = edge_r;
      end
      if (gr > 0) begin : g_u
        assign nu = w_out[gr-1][gc];
      end else begin : g_ue
        assign nu = edge_u;
      end
      if (gr < MN - 1) begin : g_d
        assign nd = w_out[gr+1][gc];
      end else begin : g_de
        assign nd = edge_d;
      end

      mesh_sort_pe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SQRT_N(MN),
        .ROW(gr), .COL(gc), .PASSES(MP)
      ) u_pe (
        .clk(clk), .rst(rst), .i_start(start), .i_load(r_load[gr][gc]),
        .i_PE_l(nl), .i_PE_r(nr), .i_PE_u(nu), .i_PE_d(nd),
        .o_PE(w_out[gr][gc]), .o_busy(w_busy[gr][gc]), .o_done(w_done[gr][gc])
`ifdef MESH_SORT_PE_STATS_EN
        , .o_swaps(swaps)
`endif
      );
    end
  end

  mesh_sort_pe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SQRT_N(1), .ROW(0), .COL(0), .PASSES(1)) u_one (
    .clk(clk), .rst(rst), .i_start(start1), .i_load(load1),
    .i_PE_l(edge_l), .i_PE_r(edge_r), .i_PE_u(edge_u), .i_PE_d(edge_d),
    .o_PE(one_pe), .o_busy(one_busy), .o_done(one_done)
`ifdef MESH_SORT_PE_STATS_EN
    , .o_swaps(one_swaps)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] key(input logic [W-1:0] e);
    return {e[DW-1:0], e[W-1:DW]};
  endfunction

  // Place the smaller element at (r0,c0) when asc, else at (r1,c1).
  task automatic order(input int r0, input int c0, input int r1, input int c1, input bit asc);
    logic [W-1:0] a, b, lo, hi;
    a  = mdl[r0][c0];
    b  = mdl[r1][c1];
    lo = (key(a) < key(b)) ? a : b;
    hi = (key(a) < key(b)) ? b : a;
    mdl[r0][c0] = asc ? lo : hi;
    mdl[r1][c1] = asc ? hi : lo;
  endtask

  // Step k of the run: phases alternate row/column, each phase is MN odd-even transposition rounds.
  task automatic model_step(input int k);
    int ph, s;
    ph = k / MN;
    s  = k % MN;
    if (ph % 2 == 0) begin
      for (int r = 0; r < MN; r++)
        for (int c = 0; c < MN - 1; c++)
          if ((c + s) % 2 == 0) order(r, c, r, c + 1, (r % 2) == 0);
    end else begin
      for (int c = 0; c < MN; c++)
        for (int r = 0; r < MN - 1; r++)
          if ((r + s) % 2 == 0) order(r, c, r + 1, c, 1'b1);
    end
  endtask

  task automatic clear_model();
    mk = 0;
    for (int r = 0; r < MN; r++)
      for (int c = 0; c < MN; c++) mdl[r][c] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      clear_model();
    end else if (mk == 0) begin
      if (start) begin
        mdl      = r_load;
        ld_saved = r_load;
        mk       = 1;
      end
    end else if (mk <= T) begin
      model_step(mk - 1);
      mk++;
    end else begin
      mk = 0;
    end
    #1;
    if (rnd_edges) begin
      edge_l = W'($urandom);
      edge_r = W'($urandom);
      edge_u = W'($urandom);
      edge_d = W'($urandom);
    end
  endtask

  task automatic randomize_loads(input bool_ties);
  endtask

  task automatic new_loads(input bit ties);
    for (int r = 0; r < MN; r++)
      for (int c = 0; c < MN; c++)
        r_load[r][c] = {AW'($urandom), ties ? DW'($urandom_range(0, 3)) : DW'($urandom)};
  endtask

  // Wait for DONE, then pin the model against the fully sorted snake order of the loaded elements.
  task automatic finish_run(input int already);
    int n;
    logic [W-1:0] s [MN*MN];
    logic [W-1:0] tmp;
    int idx;
    n = already;
    while (mk != T + 1 && n < 200) begin
      start = rnd_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (rnd_start) new_loads(1'b0);
      tick();
      n++;
    end
    start = 1'b0;
    check("run_len", n, T);
    check("done_flag", w_done[MN-1][0], 1'b1);
    for (int r = 0; r < MN; r++)
      for (int c = 0; c < MN; c++) s[r*MN + c] = ld_saved[r][c];
    for (int i = 0; i < MN*MN; i++)
      for (int j = i + 1; j < MN*MN; j++)
        if (key(s[j]) < key(s[i])) begin
          tmp  = s[i];
          s[i] = s[j];
          s[j] = tmp;
        end
    for (int r = 0; r < MN; r++)
      for (int c = 0; c < MN; c++) begin
        idx = r * MN + (((r % 2) == 0) ? c : MN - 1 - c);
        check($sformatf("sorted_pe%0d%0d", r, c), w_out[r][c], s[idx]);
      end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int r = 0; r < MN; r++)
        for (int c = 0; c < MN; c++) begin
          check($sformatf("pe%0d%0d_elem", r, c), w_out[r][c], mdl[r][c]);
          check($sformatf("pe%0d%0d_busy", r, c), w_busy[r][c], (mk >= 1) && (mk <= T));
          check($sformatf("pe%0d%0d_done", r, c), w_done[r][c], mk == T + 1);
        end
    end
  end

  initial begin
    int n;
    new_loads(1'b0);
    clear_model();
    #2;
    for (int r = 0; r < MN; r++)
      for (int c = 0; c < MN; c++) begin
        check($sformatf("rst_pe%0d%0d_elem", r, c), w_out[r][c], '0);
        check($sformatf("rst_pe%0d%0d_busy", r, c), w_busy[r][c], 1'b0);
      end
    check("rst_one_done", one_done, 1'b0);
    #4 rst = 1'b0;
    chk_en = 1'b1;

    // 1x1 mesh: start edge plus three single-step phases before DONE.
    load1  = 6'b010_101;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 1;
    while (!one_done && n < 20) begin
      tick();
      n++;
    end
    check("one_latency", n, 4);
    check("one_elem", one_pe, 6'b010_101);
    check("one_busy_at_done", one_busy, 1'b0);

    // Directed first steps with hostile edge values on every missing partner.
    edge_l = '1; edge_r = '1; edge_u = '1; edge_d = '1;
    r_load[0][0] = 6'b000_111;
    r_load[0][1] = 6'b001_011;
    r_load[1][0] = 6'b010_010;
    r_load[1][1] = 6'b011_101;
    r_load[1][2] = 6'b101_001;
    r_load[2][0] = 6'b001_100;
    r_load[2][1] = 6'b000_100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("asc_row_min", w_out[0][0], 6'b001_011);
    check("desc_row_max", w_out[1][0], 6'b011_101);
    check("addr_tiebreak", w_out[2][0], 6'b000_100);
    check("right_absent_hold", w_out[1][2], 6'b101_001);
    tick();
    check("left_absent_hold", w_out[0][0], 6'b001_011);
    finish_run(2);
    repeat (3) tick();

    // Random runs: random edges, tie-heavy keys, stray i_start and i_load churn while busy.
    rnd_edges = 1'b1;
    rnd_start = 1'b1;
    for (int run = 0; run < 8; run++) begin
      new_loads(run % 2 == 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      finish_run(0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end

    // Asynchronous reset in the middle of a column phase; the run must not resume.
    new_loads(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (MN + 1) tick();
    #2 rst = 1'b1;
    clear_model();
    #1;
    for (int r = 0; r < MN; r++)
      for (int c = 0; c < MN; c++) begin
        check($sformatf("midrst_pe%0d%0d_elem", r, c), w_out[r][c], '0);
        check($sformatf("midrst_pe%0d%0d_busy", r, c), w_busy[r][c], 1'b0);
      end
    tick();
    rst = 1'b0;
    repeat (4) tick();
    new_loads(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_run(0);
    repeat (2) tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
